rom_port_arbiter: RTL

Shares the single combinational boot/instruction ROM between the core's instruction-fetch port (I) and data-load port (D), so constants and tables in ROM can be read with loads. Per-cycle arbitration gives D fixed priority, with a starvation guard for I. Responses are registered. Misaligned and out-of-range accesses return an error. Sits between the core's two memory request ports and the ROM's addr/inst pins.

---
 rtl/rom_port_arbiter_if.sv | 31 +++
 rtl/rom_port_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/rom_port_arbiter_if.sv
// Core-side bundle for the shared ROM: instruction-fetch (i_*) and data-load (d_*) ports.
interface rom_port_arbiter_if #(
  parameter int unsigned AW = 12
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          i_err;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;

  // Core side: issues requests, consumes grants and responses
  modport master (
    output i_req, i_addr, d_req, d_addr,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err
  );

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one combinational ROM between the fetch and load ports.
// Load port has fixed priority; a saturating wait counter lets a starved fetch win.
// Responses are registered with a fixed one-cycle latency.
module rom_port_arbiter #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned AW       = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  rom_port_arbiter_if.slave   bus,
  output logic [AW-1:0]       rom_addr,
  input  logic [31:0]         rom_inst
);

  localparam int unsigned WCW = 4;
  localparam logic [WCW-1:0] MAX_WAIT_CNT = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt;
  logic           sel_i;
  logic           sel_d;
  logic [AW-1:0]  gnt_addr;
  logic           gnt_err;
  logic [31:0]    gnt_data;

  // Arbitration, ROM address mux and error decode for the granted request
  always_comb begin
    sel_i    = bus.i_req & (~bus.d_req | (wait_cnt >= MAX_WAIT_CNT));
    sel_d    = bus.d_req & ~sel_i;
    gnt_addr = sel_i ? bus.i_addr : bus.d_addr;
    rom_addr = '0;
    if (sel_i || sel_d) begin
      rom_addr = {gnt_addr[AW-1:2], 2'b00};
    end
    gnt_err  = (gnt_addr[1:0] != 2'b00) | (32'(gnt_addr[AW-1:2]) >= 32'(DEPTH));
    gnt_data = gnt_err ? 32'h0 : rom_inst;
    bus.i_gnt = sel_i;
    bus.d_gnt = sel_d;
  end

  // Starvation counter: consecutive cycles a fetch request was denied
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!bus.i_req || sel_i) begin
      wait_cnt <= '0;
    end else if (wait_cnt < MAX_WAIT_CNT) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // Fetch response register; data/err hold while no new grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.i_rvalid <= 1'b0;
      bus.i_rdata  <= 32'h0;
      bus.i_err    <= 1'b0;
    end else begin
      bus.i_rvalid <= sel_i;
      if (sel_i) begin
        bus.i_rdata <= gnt_data;
        bus.i_err   <= gnt_err;
      end
    end
  end

  // Load response register; data/err hold while no new grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.d_rvalid <= 1'b0;
      bus.d_rdata  <= 32'h0;
      bus.d_err    <= 1'b0;
    end else begin
      bus.d_rvalid <= sel_d;
      if (sel_d) begin
        bus.d_rdata <= gnt_data;
        bus.d_err   <= gnt_err;
      end
    end
  end

endmodule
